// File: rtl/fft_band_power.sv
// rtl/fft_band_power.sv - octave-band mean power of a 512-bin FFT frame (bins 1..255, 8 bands)
// Optional peak-hold with per-frame decay when FFT_BAND_PEAK_HOLD_EN is defined.
module fft_band_power #(
  parameter int DECAY_SHIFT = 3
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_ce,
  input  logic [15:0]  i_sample,
  input  logic         i_sync,
  output logic [127:0] o_band,
  output logic         o_valid,
  output logic         o_err
);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t     state;
  logic [8:0] cnt;

  logic       take;
  logic       resync;
  logic [8:0] bin_now;

  // cnt holds the index of the last accepted bin; the incoming sample is cnt+1.
  always_comb begin
    take    = 1'b0;
    resync  = 1'b0;
    bin_now = 9'd0;
    if (i_ce) begin
      if (state == S_RUN) begin
        take = 1'b1;
        if (i_sync && cnt != 9'd511) resync = 1'b1;
        else                         bin_now = cnt + 9'd1;
      end else if (i_sync) begin
        take = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_WAIT;
      cnt   <= 9'd0;
      o_err <= 1'b0;
    end else begin
      o_err <= resync;
      if (take) begin
        state <= S_RUN;
        cnt   <= bin_now;
      end
    end
  end

  logic [7:0]  re_mag;
  logic [7:0]  im_mag;
  logic [14:0] s1_re_sq;
  logic [14:0] s1_im_sq;
  logic [8:0]  s1_bin;
  logic        s1_valid;

  // Squaring the magnitude keeps -128 exact (0x80 -> 128 -> 16384).
  assign re_mag = i_sample[15] ? (8'd0 - i_sample[15:8]) : i_sample[15:8];
  assign im_mag = i_sample[7]  ? (8'd0 - i_sample[7:0])  : i_sample[7:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_re_sq <= 15'd0;
      s1_im_sq <= 15'd0;
      s1_bin   <= 9'd0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= take;
      if (take) begin
        s1_re_sq <= {7'd0, re_mag} * {7'd0, re_mag};
        s1_im_sq <= {7'd0, im_mag} * {7'd0, im_mag};
        s1_bin   <= bin_now;
      end
    end
  end

  logic [15:0] power;
  logic        band_hit;
  logic [2:0]  band_idx;

  assign power = {1'b0, s1_re_sq} + {1'b0, s1_im_sq};

  always_comb begin
    band_hit = (s1_bin[8] == 1'b0) && (s1_bin[7:0] != 8'd0);
    band_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (s1_bin[k]) band_idx = 3'(k);
    end
  end

  logic [22:0] acc [8];
  logic        s2_pub;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < 8; k++) acc[k] <= 23'd0;
      s2_pub <= 1'b0;
    end else begin
      s2_pub <= s1_valid && (s1_bin == 9'd255);
      if (s1_valid) begin
        if (s1_bin == 9'd0) begin
          for (int k = 0; k < 8; k++) acc[k] <= 23'd0;
        end else if (band_hit) begin
          acc[band_idx] <= acc[band_idx] + {7'd0, power};
        end
      end
    end
  end

  logic [127:0] next_band;
  logic [15:0]  level;

`ifdef FFT_BAND_PEAK_HOLD_EN
  logic [15:0] prev;
  logic [15:0] decayed;

  always_comb begin
    next_band = 128'd0;
    level     = 16'd0;
    prev      = 16'd0;
    decayed   = 16'd0;
    for (int k = 0; k < 8; k++) begin
      level   = 16'(acc[k] >> k);
      prev    = o_band[16*k +: 16];
      decayed = prev - (prev >> DECAY_SHIFT);
      next_band[16*k +: 16] = (level > decayed) ? level : decayed;
    end
  end
`else
  logic unused_decay;
  assign unused_decay = |DECAY_SHIFT;

  always_comb begin
    next_band = 128'd0;
    level     = 16'd0;
    for (int k = 0; k < 8; k++) begin
      level = 16'(acc[k] >> k);
      next_band[16*k +: 16] = level;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_band  <= 128'd0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= s2_pub;
      if (s2_pub) o_band <= next_band;
    end
  end

endmodule
